dp_byte_ram: RTL and testbench

//  Parametrised dual-port, byte-lane-enabled main memory for instruction fetch (port A) and data load/store (port B).

---
 rtl/dp_byte_ram_pkg.sv | 14 +
 rtl/dp_byte_lane.sv | 32 +++
 rtl/dp_byte_ram.sv | 182 ++++++++++++++++++
 tb/tb_dp_byte_ram.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dp_byte_ram_pkg.sv
// Shared types and helpers for the dual-port byte-lane RAM.
package mem_pkg;

  typedef enum logic {ST_INIT, ST_RUN} mem_state_e;

  // Deepest read pipeline supported: BRAM output plus one extra register.
  localparam int MAX_LAT = 2;

  // Number of byte lanes in a word of the given bit width.
  function automatic int lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/dp_byte_lane.sv
// One 8-bit wide true-dual-port BRAM slice. No reset on the array or the
// output registers, so the tools can map it onto block RAM. Reads are
// read-first: a read returns the word as it was before this edge's writes.
module dp_byte_lane #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic          re_a,
  input  logic [AW-1:0] addr_a,
  input  logic [7:0]    din_a,
  output logic [7:0]    dout_a,
  input  logic          we_b,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  input  logic [7:0]    din_b,
  output logic [7:0]    dout_b
);

  logic [7:0] mem [DEPTH];

  // Both ports write and read the array; the top guarantees the two ports
  // never write the same address of a lane in the same cycle.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
    if (we_a) mem[addr_a] <= din_a;
    if (re_a) dout_a <= mem[addr_a];
    if (re_b) dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/dp_byte_ram.sv
// Dual-port byte-lane-enabled main memory: port A for instruction fetch,
// port B for load/store. Zero-fills itself after reset when INIT_ZERO=1,
// resolves same-word write/write collisions in favour of port A and
// forwards same-cycle cross-port write data into reads.
module dp_byte_ram
  import mem_pkg::*;
#(
  parameter int MEM_SIZE     = 8192,
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1,
  localparam int LANES       = lanes(WIDTH),
  localparam int AW          = $clog2(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [LANES-1:0] be_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic             ready_a,
  output logic             rvalid_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [LANES-1:0] be_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             ready_b,
  output logic             rvalid_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             init_busy
);

  localparam int LW    = $clog2(LANES);
  localparam int DEPTH = MEM_SIZE / LANES;
  localparam int WAW   = AW - LW;

  mem_state_e     state;
  logic [WAW-1:0] init_cnt;
  logic           ready_q;

  // Byte-offset bits inside a word carry no information for a word access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_a, addr_b};

  // Zero-fill sequencer and ready generation; RUN is left only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      init_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == WAW'(DEPTH - 1)) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  logic init_active;
  assign init_active = (state == ST_INIT);
  assign init_busy   = init_active;
  assign ready_a     = ready_q;
  assign ready_b     = ready_q;

  logic           wr_a, rd_a, wr_b, rd_b, same_word;
  logic [WAW-1:0] word_a, word_b;
  logic [LANES-1:0] be_b_eff;

  assign wr_a      = req_a & ready_q & we_a;
  assign rd_a      = req_a & ready_q & ~we_a;
  assign wr_b      = req_b & ready_q & we_b;
  assign rd_b      = req_b & ready_q & ~we_b;
  assign word_a    = addr_a[AW-1:LW];
  assign word_b    = addr_b[AW-1:LW];
  assign same_word = (word_a == word_b);
  // Port A owns every lane it writes when both ports hit the same word.
  assign be_b_eff  = (wr_a && same_word) ? (be_b & ~be_a) : be_b;

  logic [WIDTH-1:0] dout_a, dout_b;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dp_byte_lane #(
      .DEPTH (DEPTH),
      .AW    (WAW)
    ) u_lane (
      .clk    (clk),
      .we_a   (init_active | (wr_a & be_a[i])),
      .re_a   (rd_a),
      .addr_a (init_active ? init_cnt : word_a),
      .din_a  (init_active ? 8'h00 : wdata_a[8*i +: 8]),
      .dout_a (dout_a[8*i +: 8]),
      .we_b   (wr_b & be_b_eff[i]),
      .re_b   (rd_b),
      .addr_b (word_b),
      .din_b  (wdata_b[8*i +: 8]),
      .dout_b (dout_b[8*i +: 8])
    );
  end

  // ---- stage p0: BRAM output plus captured cross-port write for forwarding
  logic [LANES-1:0] fwd_mask_a_p0, fwd_mask_b_p0;
  logic [WIDTH-1:0] fwd_data_a_p0, fwd_data_b_p0;
  logic             vld_a_p0, vld_b_p0;
  logic [WIDTH-1:0] word_a_p0, word_b_p0;

  // Capture which lanes the other port wrote to the word being read.
  always_ff @(posedge clk) begin
    if (rd_a) begin
      fwd_mask_a_p0 <= (wr_b && same_word) ? be_b_eff : '0;
      fwd_data_a_p0 <= wdata_b;
    end
    if (rd_b) begin
      fwd_mask_b_p0 <= (wr_a && same_word) ? be_a : '0;
      fwd_data_b_p0 <= wdata_a;
    end
  end

  // Read-valid tokens; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_p0 <= 1'b0;
      vld_b_p0 <= 1'b0;
    end else begin
      vld_a_p0 <= rd_a;
      vld_b_p0 <= rd_b;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_fwd
    assign word_a_p0[8*i +: 8] = fwd_mask_a_p0[i] ? fwd_data_a_p0[8*i +: 8] : dout_a[8*i +: 8];
    assign word_b_p0[8*i +: 8] = fwd_mask_b_p0[i] ? fwd_data_b_p0[8*i +: 8] : dout_b[8*i +: 8];
  end

  // ---- stage p1: holding register, also the extra output stage at latency 2
  logic [WIDTH-1:0] rdata_a_p1, rdata_b_p1;

  // Keep the most recent read word so rdata holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_p1 <= '0;
      rdata_b_p1 <= '0;
    end else begin
      if (vld_a_p0) rdata_a_p1 <= word_a_p0;
      if (vld_b_p0) rdata_b_p1 <= word_b_p0;
    end
  end

  if (READ_LATENCY >= MAX_LAT) begin : g_lat2
    logic vld_a_p1, vld_b_p1;

    // Delay the valid token to match the extra output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_a_p1 <= 1'b0;
        vld_b_p1 <= 1'b0;
      end else begin
        vld_a_p1 <= vld_a_p0;
        vld_b_p1 <= vld_b_p0;
      end
    end

    assign rvalid_a = vld_a_p1;
    assign rvalid_b = vld_b_p1;
    assign rdata_a  = rdata_a_p1;
    assign rdata_b  = rdata_b_p1;
  end else begin : g_lat1
    assign rvalid_a = vld_a_p0;
    assign rvalid_b = vld_b_p0;
    assign rdata_a  = vld_a_p0 ? word_a_p0 : rdata_a_p1;
    assign rdata_b  = vld_b_p0 ? word_b_p0 : rdata_b_p1;
  end

endmodule

// File: tb/tb_dp_byte_ram.sv
// Directed bench for dp_byte_ram: one latency-1 and one latency-2 instance
// share clock, reset and stimulus.
module tb_dp_byte_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [5:0]  addr_a = '0, addr_b = '0;
  logic [3:0]  be_a = '0, be_b = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;

  logic        ready_a1, rvalid_a1, ready_b1, rvalid_b1, busy1;
  logic [31:0] rdata_a1, rdata_b1;
  logic        ready_a2, rvalid_a2, ready_b2, rvalid_b2, busy2;
  logic [31:0] rdata_a2, rdata_b2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dp_byte_ram #(.MEM_SIZE(64), .WIDTH(32), .READ_LATENCY(1), .INIT_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .be_a(be_a), .wdata_a(wdata_a),
    .ready_a(ready_a1), .rvalid_a(rvalid_a1), .rdata_a(rdata_a1),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .be_b(be_b), .wdata_b(wdata_b),
    .ready_b(ready_b1), .rvalid_b(rvalid_b1), .rdata_b(rdata_b1),
    .init_busy(busy1)
  );

  dp_byte_ram #(.MEM_SIZE(64), .WIDTH(32), .READ_LATENCY(2), .INIT_ZERO(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .be_a(be_a), .wdata_a(wdata_a),
    .ready_a(ready_a2), .rvalid_a(rvalid_a2), .rdata_a(rdata_a2),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .be_b(be_b), .wdata_b(wdata_b),
    .ready_b(ready_b2), .rvalid_b(rvalid_b2), .rdata_b(rdata_b2),
    .init_busy(busy2)
  );

  typedef struct {
    logic        port;   // 0 = A, 1 = B
    logic        we;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 1'b0; we_a = 1'b0; be_a = '0;
    req_b = 1'b0; we_b = 1'b0; be_b = '0;
  endtask

  task automatic wr_a(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
    req_a = 1'b1; we_a = 1'b1; addr_a = a; be_a = be; wdata_a = d;
    tick();
    idle();
  endtask

  // Clock until both instances leave INIT; returns cycle count, flags early ready/rvalid.
  task automatic count_init(input string name, output int n);
    logic bad;
    n = 0;
    bad = 1'b0;
    while ((busy1 || busy2) && n < 100) begin
      if (ready_a1 || ready_b1 || ready_a2 || ready_b2) bad = 1'b1;
      if (rvalid_a1 || rvalid_b1 || rvalid_a2 || rvalid_b2) bad = 1'b1;
      tick();
      n++;
    end
    chk({name, "_quiet_during_init"}, 32'(bad), 32'd0);
    chk({name, "_init_cycles"}, 32'(n), 32'd16);
    chk({name, "_busy_sync"}, 32'(busy1 ^ busy2), 32'd0);
    chk({name, "_ready_after"}, {28'd0, ready_a1, ready_b1, ready_a2, ready_b2}, 32'hF);
  endtask

  initial begin
    int n;
    logic [31:0] vals[4];
    logic rv;
    logic [31:0] rd;

    vecs[0] = '{1'b0, 1'b1, 6'h08, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 6'h0A, 4'b0001, 32'h000000AA, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 6'h08, 4'b0000, 32'h0,        32'hDEADBEAA};
    vecs[3] = '{1'b1, 1'b1, 6'h08, 4'b0000, 32'hFFFFFFFF, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 6'h08, 4'b0000, 32'h0,        32'hDEADBEAA};
    vecs[5] = '{1'b1, 1'b1, 6'h0C, 4'b1010, 32'h11223344, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 6'h0C, 4'b0000, 32'h0,        32'h11003300};
    vecs[7] = '{1'b0, 1'b0, 6'h3C, 4'b0000, 32'h0,        32'h00000000};

    // Reset state
    #1;
    chk("rst_ready", {30'd0, ready_a1, ready_b1}, 32'd0);
    chk("rst_rvalid", {28'd0, rvalid_a1, rvalid_b1, rvalid_a2, rvalid_b2}, 32'd0);
    chk("rst_rdata", rdata_a1 | rdata_b1 | rdata_a2 | rdata_b2, 32'd0);
    chk("rst_busy", {30'd0, busy1, busy2}, 32'd3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-fill duration
    count_init("init1", n);

    // Table-driven single-port accesses
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].port) begin
        req_b = 1'b1; we_b = vecs[i].we; addr_b = vecs[i].addr; be_b = vecs[i].be; wdata_b = vecs[i].wdata;
      end else begin
        req_a = 1'b1; we_a = vecs[i].we; addr_a = vecs[i].addr; be_a = vecs[i].be; wdata_a = vecs[i].wdata;
      end
      tick();
      idle();
      rv = vecs[i].port ? rvalid_b1 : rvalid_a1;
      rd = vecs[i].port ? rdata_b1 : rdata_a1;
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_wr_rvalid", i), 32'(rv), 32'd0);
      end else begin
        chk($sformatf("vec%0d_rvalid", i), 32'(rv), 32'd1);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        tick();
        rv = vecs[i].port ? rvalid_b1 : rvalid_a1;
        rd = vecs[i].port ? rdata_b1 : rdata_a1;
        chk($sformatf("vec%0d_pulse", i), 32'(rv), 32'd0);
        chk($sformatf("vec%0d_hold", i), rd, vecs[i].exp);
      end
    end

    // Same-cycle write/write collision: A wins on shared lanes
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'h10; be_a = 4'b0011; wdata_a = 32'h11223344;
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'h10; be_b = 4'b0110; wdata_b = 32'hAABBCCDD;
    tick();
    idle();
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'h10;
    tick();
    idle();
    chk("ww_collision", rdata_b1, 32'h00BB3344);

    // A reads while B writes the same word: forwarded lanes
    wr_a(6'h14, 4'b1111, 32'hCAFEF00D);
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h14;
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'h14; be_b = 4'b1100; wdata_b = 32'h12345678;
    tick();
    idle();
    chk("fwd_b_to_a_valid", 32'(rvalid_a1), 32'd1);
    chk("fwd_b_to_a", rdata_a1, 32'h1234F00D);
    chk("fwd_b_to_a_lat2", rdata_a2, 32'h0);
    tick();
    chk("fwd_b_to_a_lat2_out", rdata_a2, 32'h1234F00D);

    // B reads while A writes the same word
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'h18;
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'h19; be_a = 4'b0101; wdata_a = 32'hA5A5A5A5;
    tick();
    idle();
    chk("fwd_a_to_b", rdata_b1, 32'h00A500A5);
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h18;
    tick();
    idle();
    chk("fwd_a_to_b_stored", rdata_a1, 32'h00A500A5);

    // Back-to-back reads on both latencies
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'h10203040 + 32'(i) * 32'h01010101;
      wr_a(6'(6'h20 + 4 * i), 4'b1111, vals[i]);
    end
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        req_a = 1'b1; we_a = 1'b0; addr_a = 6'(6'h20 + 4 * c);
      end else begin
        idle();
      end
      tick();
      chk($sformatf("b2b_lat1_vld%0d", c), 32'(rvalid_a1), (c < 4) ? 32'd1 : 32'd0);
      if (c < 4) chk($sformatf("b2b_lat1_data%0d", c), rdata_a1, vals[c]);
      chk($sformatf("b2b_lat2_vld%0d", c), 32'(rvalid_a2), (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 4) chk($sformatf("b2b_lat2_data%0d", c), rdata_a2, vals[c - 1]);
    end
    idle();

    // Reset with a read in flight in the latency-2 instance
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h20;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midread_rvalid", {28'd0, rvalid_a1, rvalid_b1, rvalid_a2, rvalid_b2}, 32'd0);
    chk("midread_rdata", rdata_a1 | rdata_a2, 32'd0);
    chk("midread_busy", {30'd0, busy1, busy2}, 32'd3);
    tick();
    chk("midread_no_late_vld", 32'(rvalid_a2), 32'd0);
    #1 rst_n = 1'b1;

    // Reset at INIT cycle 5, request held throughout to prove it is ignored
    repeat (5) tick();
    chk("midinit_busy", {30'd0, busy1, busy2}, 32'd3);
    rst_n = 1'b0;
    tick();
    #1 rst_n = 1'b1;
    count_init("init2", n);
    idle();
    chk("post_init_no_vld", {30'd0, rvalid_a1, rvalid_a2}, 32'd0);
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h08;
    tick();
    idle();
    chk("refill_zero", rdata_a1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
